// File: rtl/vie_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : vie_mem_stage
// Description : MEM stage of the vie MIPS pipeline, between EX and WB.
//               Collects load/store responses from the data-side SRAM-like
//               interface and aligns and extends load data. Exceptions, CP0
//               fields and the ALU result go to WB unchanged. A flush from WB
//               kills the entry held here. Any load response still in flight
//               for a killed entry is counted and dropped when it arrives.
//
// Ports       : clock              system clock
//               reset              synchronous, active-high reset
//               esbus_i[127:0]     EX->MEM bus
//                                  [127] valid [126:95] baddr [94] bd
//                                  [93:86] op [85:78] cp0_addr [77:72] exc
//                                  [71:65] dest [64:33] pc [32:1] res
//                                  [0] ld_wait
//               ms_allowin         MEM can accept esbus_i this cycle
//               ws_allowin         WB can accept msbus_o this cycle
//               flush_i            flush from WB, kills MEM contents
//               data_sram_data_ok  response beat (in order, one per request)
//               data_sram_rdata    load response data
//               msbus_o[126:0]     MEM->WB bus: esbus layout without ld_wait,
//                                  with [31:0] holding the final result
//               msfwd_o[38:0]      bypass: [38] valid [37] ready
//                                  [36:32] dest [31:0] data
//
// Parameters  : DISCARD_W          width of the orphan-response counter
//
// Macros      : VIE_MS_FWD_EN      drives the MEM->ID bypass bus. When the
//                                  macro is not defined, msfwd_o is tied to 0.
//
// Op codes    : LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
//               Any other op keeps res.
//
// Revision    : 1.0  initial release
// ============================================================================
module vie_mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] esbus_i,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  input  logic         flush_i,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [126:0] msbus_o,
  output logic [38:0]  msfwd_o
);

  localparam logic [7:0] C_OP_LB  = 8'h20;
  localparam logic [7:0] C_OP_LH  = 8'h21;
  localparam logic [7:0] C_OP_LW  = 8'h23;
  localparam logic [7:0] C_OP_LBU = 8'h24;
  localparam logic [7:0] C_OP_LHU = 8'h25;

  localparam logic [DISCARD_W-1:0] C_DISCARD_MAX  = '1;
  localparam logic [DISCARD_W-1:0] C_DISCARD_ZERO = '0;
  localparam logic [DISCARD_W-1:0] C_DISCARD_ONE  = {{(DISCARD_W-1){1'b0}}, 1'b1};

  // WAIT: the load/store response has not been seen yet.
  // HOLD: the response was taken while WB was stalled, so it sits in r_data_buf.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_ms_valid;
  logic [126:0]           r_es;          // latched entry without its valid bit
  logic [31:0]            r_data_buf;
  logic [DISCARD_W-1:0]   r_discard_cnt;

  logic                   w_ld_wait;
  logic                   w_data_got;
  logic                   w_match;
  logic                   w_ms_cango;
  logic                   w_leave;
  logic                   w_accept;
  logic                   w_inc;
  logic                   w_dec;
  logic [31:0]            w_raw;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [31:0]            w_result;
  logic [1:0]             w_off;
  logic [7:0]             w_op;
  logic [31:0]            w_res;

  assign w_ld_wait  = r_es[0];
  assign w_op       = r_es[93:86];
  assign w_off      = r_es[96:95];
  assign w_res      = r_es[32:1];
  assign w_data_got = (r_state == S_HOLD);

  // The counter is zero only after every orphaned response has drained.
  // Responses arrive in order, so the next beat then belongs to this entry.
  assign w_match    = data_sram_data_ok && (r_discard_cnt == C_DISCARD_ZERO);
  assign w_ms_cango = !w_ld_wait || w_data_got || w_match;

  assign ms_allowin = !r_ms_valid || (w_ms_cango && ws_allowin);
  assign w_leave    = r_ms_valid && w_ms_cango && ws_allowin;
  assign w_accept   = esbus_i[127] && ms_allowin && !flush_i;

  // A flushed entry that is still waiting leaves one orphaned response behind,
  // unless that response arrives in the flush cycle itself.
  assign w_inc = flush_i && (r_state == S_WAIT) && !w_match;
  assign w_dec = data_sram_data_ok && (r_discard_cnt != C_DISCARD_ZERO);

  // Load data alignment and extension
  assign w_raw = w_data_got ? r_data_buf : data_sram_rdata;

  always_comb begin
    w_byte = w_raw[7:0];
    case (w_off)
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
  end

  assign w_half = w_off[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_result = w_res;
    case (w_op)
      C_OP_LB:  w_result = {{24{w_byte[7]}}, w_byte};
      C_OP_LBU: w_result = {24'h0, w_byte};
      C_OP_LH:  w_result = {{16{w_half[15]}}, w_half};
      C_OP_LHU: w_result = {16'h0, w_half};
      C_OP_LW:  w_result = w_raw;
      default:  w_result = w_res;
    endcase
  end

  assign msbus_o = {r_ms_valid && w_ms_cango && !flush_i, r_es[126:33], w_result};

`ifdef VIE_MS_FWD_EN
  logic [6:0] w_dest;
  assign w_dest  = r_es[71:65];
  assign msfwd_o = {r_ms_valid && (w_dest[6:5] == 2'b00), w_ms_cango, w_dest[4:0], w_result};
`else
  assign msfwd_o = 39'h0;
`endif

  // Entry FSM and the discard counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ms_valid    <= 1'b0;
      r_es          <= '0;
      r_data_buf    <= 32'h0;
      r_discard_cnt <= C_DISCARD_ZERO;
    end else begin
      if (flush_i) begin
        r_state    <= S_IDLE;
        r_ms_valid <= 1'b0;
      end else begin
        if (w_leave) begin
          r_state    <= S_IDLE;
          r_ms_valid <= 1'b0;
        end else if ((r_state == S_WAIT) && w_match) begin
          // WB is stalled, so buffer the response. The sender may change rdata later.
          r_state    <= S_HOLD;
          r_data_buf <= data_sram_rdata;
        end
        if (w_accept) begin
          r_es       <= esbus_i[126:0];
          r_ms_valid <= 1'b1;
          r_state    <= esbus_i[0] ? S_WAIT : S_IDLE;
        end
      end

      case ({w_inc, w_dec})
        2'b10: if (r_discard_cnt != C_DISCARD_MAX)
                 r_discard_cnt <= r_discard_cnt + C_DISCARD_ONE;
        2'b01: r_discard_cnt <= r_discard_cnt - C_DISCARD_ONE;
        default: r_discard_cnt <= r_discard_cnt;
      endcase
    end
  end

  // More responses are in flight than the counter can track.
  a_discard_not_full: assert property (@(posedge clock) disable iff (reset)
    r_discard_cnt != C_DISCARD_MAX);

endmodule
`default_nettype wire

// File: tb/tb_vie_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vie_mem_stage
// Description : Directed, table-driven bench for vie_mem_stage. It covers the
//               load alignment vectors plus hand sequences for flush, discard,
//               WB back-pressure and non-load forwarding.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vie_mem_stage;

  localparam logic [7:0] OP_LB   = 8'h20;
  localparam logic [7:0] OP_LH   = 8'h21;
  localparam logic [7:0] OP_LW   = 8'h23;
  localparam logic [7:0] OP_LBU  = 8'h24;
  localparam logic [7:0] OP_LHU  = 8'h25;
  localparam logic [7:0] OP_SW   = 8'h2B;
  localparam logic [7:0] OP_ADDU = 8'h01;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] esbus_i;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         flush_i;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [126:0] msbus_o;
  logic [38:0]  msfwd_o;

  int n_checks = 0;
  int n_errors = 0;

  vie_mem_stage #(.DISCARD_W(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .esbus_i           (esbus_i),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .flush_i           (flush_i),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .msbus_o           (msbus_o),
    .msfwd_o           (msfwd_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] baddr;
    logic [31:0] res;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] op, input logic [31:0] baddr,
                                      input logic [5:0] exc, input logic [6:0] dest,
                                      input logic [31:0] pc, input logic [31:0] res,
                                      input logic ld_wait);
    return {1'b1, baddr, 1'b0, op, 8'h00, exc, dest, pc, res, ld_wait};
  endfunction

  task automatic send(input logic [127:0] es);
    esbus_i = es;
    tick();
    esbus_i = '0;
  endtask

  initial begin
    vecs[0] = '{OP_LW,  32'h0000_1000, 32'h0, 3, 32'h8765_4321, 32'h8765_4321};
    vecs[1] = '{OP_LB,  32'h0000_1003, 32'h0, 1, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[2] = '{OP_LBU, 32'h0000_1003, 32'h0, 1, 32'h80FF_0000, 32'h0000_0080};
    vecs[3] = '{OP_LH,  32'h0000_1002, 32'h0, 2, 32'h80FF_0000, 32'hFFFF_80FF};
    vecs[4] = '{OP_LHU, 32'h0000_1000, 32'h0, 0, 32'h80FF_0000, 32'h0000_0000};
    vecs[5] = '{OP_LB,  32'h0000_1002, 32'h0, 0, 32'h80FF_0000, 32'hFFFF_FFFF};
    vecs[6] = '{OP_LBU, 32'h0000_1001, 32'h0, 1, 32'h1234_A5C3, 32'h0000_00A5};
    vecs[7] = '{OP_LH,  32'h0000_1000, 32'h0, 1, 32'h1234_8765, 32'hFFFF_8765};
    vecs[8] = '{OP_LHU, 32'h0000_1002, 32'h0, 2, 32'hBEEF_0001, 32'h0000_BEEF};
    vecs[9] = '{OP_SW,  32'h0000_1004, 32'hCAFE_0001, 1, 32'h9999_9999, 32'hCAFE_0001};

    reset             = 1'b1;
    esbus_i           = '0;
    ws_allowin        = 1'b1;
    flush_i           = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    at_neg();
    chk("reset_valid",   {31'h0, msbus_o[126]}, 32'h0);
    chk("reset_fwd",     {31'h0, |msfwd_o},     32'h0);
    chk("reset_allowin", {31'h0, ms_allowin},   32'h1);

    // Table: one load/store each, with a response after vec.delay cycles
    for (int i = 0; i < NV; i++) begin
      send(mk(vecs[i].op, vecs[i].baddr, 6'h0, 7'd3, 32'h0040_0000 + 32'(i * 4), vecs[i].res, 1'b1));
      for (int k = 0; k < vecs[i].delay; k++) begin
        at_neg();
        chk("wait_valid",   {31'h0, msbus_o[126]}, 32'h0);
        chk("wait_allowin", {31'h0, ms_allowin},   32'h0);
        tick();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = vecs[i].rdata;
      at_neg();
      chk("beat_valid", {31'h0, msbus_o[126]}, 32'h1);
      chk("beat_res",   msbus_o[31:0],         vecs[i].exp);
      chk("beat_pc",    msbus_o[63:32],        32'h0040_0000 + 32'(i * 4));
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      at_neg();
      chk("after_beat_valid", {31'h0, msbus_o[126]}, 32'h0);
    end

    // A flush during WAIT leaves one orphaned response to drop
    send(mk(OP_LW, 32'h0000_3000, 6'h0, 7'd4, 32'h0040_1000, 32'h0, 1'b1));
    at_neg();
    chk("flw_allowin", {31'h0, ms_allowin}, 32'h0);
    tick();
    flush_i = 1'b1;
    at_neg();
    chk("flw_valid", {31'h0, msbus_o[126]}, 32'h0);
    tick();
    flush_i = 1'b0;
    at_neg();
    chk("flw_killed_allowin", {31'h0, ms_allowin}, 32'h1);
    send(mk(OP_LW, 32'h0000_3004, 6'h0, 7'd4, 32'h0040_1004, 32'h0, 1'b1));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_DEAD;
    at_neg();
    chk("orphan_dropped_valid", {31'h0, msbus_o[126]}, 32'h0);
    chk("orphan_allowin",       {31'h0, ms_allowin},   32'h0);
    tick();
    data_sram_rdata = 32'h0000_1234;
    at_neg();
    chk("post_orphan_valid", {31'h0, msbus_o[126]}, 32'h1);
    chk("post_orphan_res",   msbus_o[31:0],         32'h0000_1234);
    tick();
    data_sram_data_ok = 1'b0;
    at_neg();
    chk("post_orphan_gone", {31'h0, msbus_o[126]}, 32'h0);

    // A flush that coincides with the pending response does not add an orphan
    send(mk(OP_LW, 32'h0000_3008, 6'h0, 7'd4, 32'h0040_1008, 32'h0, 1'b1));
    flush_i           = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0BAD;
    at_neg();
    chk("flok_valid", {31'h0, msbus_o[126]}, 32'h0);
    tick();
    flush_i           = 1'b0;
    data_sram_data_ok = 1'b0;
    send(mk(OP_LW, 32'h0000_300C, 6'h0, 7'd4, 32'h0040_100C, 32'h0, 1'b1));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_4321;
    at_neg();
    chk("flok_next_valid", {31'h0, msbus_o[126]}, 32'h1);
    chk("flok_next_res",   msbus_o[31:0],         32'h0000_4321);
    tick();
    data_sram_data_ok = 1'b0;

    // WB back-pressure: the response is buffered and does not follow rdata
    send(mk(OP_LW, 32'h0000_2000, 6'h0, 7'd2, 32'h0040_2000, 32'h0, 1'b1));
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h55AA_55AA;
    at_neg();
    chk("hold_first_valid",   {31'h0, msbus_o[126]}, 32'h1);
    chk("hold_first_res",     msbus_o[31:0],         32'h55AA_55AA);
    chk("hold_first_allowin", {31'h0, ms_allowin},   32'h0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1111_1111;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("hold_valid",   {31'h0, msbus_o[126]}, 32'h1);
      chk("hold_res",     msbus_o[31:0],         32'h55AA_55AA);
      chk("hold_allowin", {31'h0, ms_allowin},   32'h0);
      tick();
    end
    ws_allowin = 1'b1;
    at_neg();
    chk("hold_release_valid",   {31'h0, msbus_o[126]}, 32'h1);
    chk("hold_release_res",     msbus_o[31:0],         32'h55AA_55AA);
    chk("hold_release_allowin", {31'h0, ms_allowin},   32'h1);
    tick();
    data_sram_rdata = 32'h0;
    at_neg();
    chk("hold_once", {31'h0, msbus_o[126]}, 32'h0);

    // Non-load with an exception passes straight through in one cycle
    send(mk(OP_ADDU, 32'h0, 6'b001000, 7'd5, 32'h0040_3000, 32'h0000_0007, 1'b0));
    at_neg();
    chk("addu_valid",   {31'h0, msbus_o[126]},  32'h1);
    chk("addu_exc",     {26'h0, msbus_o[76:71]}, 32'h0000_0008);
    chk("addu_res",     msbus_o[31:0],          32'h0000_0007);
    chk("addu_op",      {24'h0, msbus_o[92:85]}, {24'h0, OP_ADDU});
    chk("addu_allowin", {31'h0, ms_allowin},    32'h1);
`ifdef VIE_MS_FWD_EN
    chk("addu_fwd_valid", {31'h0, msfwd_o[38]}, 32'h1);
    chk("addu_fwd_ready", {31'h0, msfwd_o[37]}, 32'h1);
    chk("addu_fwd_data",  msfwd_o[31:0],        32'h0000_0007);
`else
    chk("addu_fwd_off", {31'h0, |msfwd_o}, 32'h0);
`endif
    tick();
    at_neg();
    chk("addu_gone", {31'h0, msbus_o[126]}, 32'h0);

    // A flush forces the outgoing valid low in the same cycle
    send(mk(OP_ADDU, 32'h0, 6'h0, 7'd6, 32'h0040_3004, 32'h0000_0009, 1'b0));
    flush_i = 1'b1;
    at_neg();
    chk("flush_force_valid", {31'h0, msbus_o[126]}, 32'h0);
    tick();
    flush_i = 1'b0;
    at_neg();
    chk("flush_after_valid",   {31'h0, msbus_o[126]}, 32'h0);
    chk("flush_after_allowin", {31'h0, ms_allowin},   32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
